// File: rtl/q_pulse_tx_if.sv
// Handshake/bus bundle for q_pulse_tx: run controls and reference in, pulse stream and status out.
// The credit_ovf signal exists only when QPT_CREDIT_OVF_EN is defined.
interface q_pulse_tx_if #(
   parameter int BUS_WIDTH = 10,
   parameter int CNT_WIDTH = 12
);
   logic                 enable;
   logic                 start;
   logic [BUS_WIDTH-1:0] i_ref;
   logic                 q_serialized;
   logic                 pulses_ended;
   logic [CNT_WIDTH-1:0] pulse_cnt;
`ifdef QPT_CREDIT_OVF_EN
   logic                 credit_ovf;
`endif

   modport master (
      output enable, start, i_ref,
      input  q_serialized, pulses_ended, pulse_cnt
`ifdef QPT_CREDIT_OVF_EN
      , input credit_ovf
`endif
   );

   modport slave (
      input  enable, start, i_ref,
      output q_serialized, pulses_ended, pulse_cnt
`ifdef QPT_CREDIT_OVF_EN
      , output credit_ovf
`endif
   );
endinterface

// File: rtl/q_pulse_tx.sv
// Charge-pulse transmitter: phase accumulator on i_ref feeds a credit counter drained by a fixed-width pulse emitter.
// Define QPT_CREDIT_OVF_EN to add the sticky credit_ovf flag for pulses dropped at credit saturation.
module q_pulse_tx #(
   parameter int BUS_WIDTH      = 10,
   parameter int ACC_WIDTH      = 10,
   parameter int PULSE_DURATION = 3,
   parameter int GAP_DURATION   = 1,
   parameter int CREDIT_WIDTH   = 4,
   parameter int CNT_WIDTH      = 12
) (
   input  logic          clk,
   input  logic          rst,
   q_pulse_tx_if.slave   bus
);
   localparam int MAX_DUR     = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
   localparam int TIMER_WIDTH = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t                  state_q, state_d;
   logic [ACC_WIDTH-1:0]    acc_q, acc_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
   logic [CNT_WIDTH-1:0]    pulse_cnt_q, pulse_cnt_d;
   logic                    q_serialized_q, q_serialized_d;
   logic                    pulses_ended_q, pulses_ended_d;
   logic                    start_q, start_d;

   logic                    run, start_edge, carry, launch, drop;
   logic [ACC_WIDTH-1:0]    acc_base;
   logic [ACC_WIDTH:0]      acc_sum;
   logic [CNT_WIDTH-1:0]    cnt_base;

   always_comb begin
      run        = bus.enable & bus.start;
      start_edge = run & ~start_q;
      start_d    = bus.start;

      // A fresh run always starts from zero phase, so no residue leaks between runs.
      acc_base = start_edge ? '0 : acc_q;
      acc_sum  = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - BUS_WIDTH){1'b0}}, bus.i_ref};
      carry    = run & acc_sum[ACC_WIDTH];
      acc_d    = run ? acc_sum[ACC_WIDTH-1:0] : '0;

      launch = (state_q == IDLE) && (credit_q != '0);
      drop   = carry & ~launch & (&credit_q);

      credit_d = credit_q;
      if (carry && !launch && !drop)
         credit_d = credit_q + CREDIT_WIDTH'(1);
      else if (launch && !carry)
         credit_d = credit_q - CREDIT_WIDTH'(1);

      cnt_base    = start_edge ? '0 : pulse_cnt_q;
      pulse_cnt_d = cnt_base;
      if (launch && (cnt_base != '1))
         pulse_cnt_d = cnt_base + CNT_WIDTH'(1);

      state_d        = state_q;
      timer_d        = timer_q;
      q_serialized_d = q_serialized_q;
      case (state_q)
         IDLE: begin
            if (launch) begin
               state_d        = HIGH;
               q_serialized_d = 1'b1;
               timer_d        = TIMER_WIDTH'(PULSE_DURATION - 1);
            end
         end
         HIGH: begin
            if (timer_q == '0) begin
               state_d        = LOW;
               q_serialized_d = 1'b0;
               timer_d        = TIMER_WIDTH'(GAP_DURATION - 1);
            end else begin
               timer_d = timer_q - TIMER_WIDTH'(1);
            end
         end
         LOW: begin
            if (timer_q == '0)
               state_d = IDLE;
            else
               timer_d = timer_q - TIMER_WIDTH'(1);
         end
         default: begin
            state_d        = IDLE;
            q_serialized_d = 1'b0;
            timer_d        = '0;
         end
      endcase

      pulses_ended_d = (credit_d == '0) && (state_d == IDLE) && (!run || (bus.i_ref == '0));
   end

`ifdef QPT_CREDIT_OVF_EN
   logic credit_ovf_q, credit_ovf_d;

   always_comb begin
      credit_ovf_d = start_edge ? 1'b0 : (credit_ovf_q | drop);
   end

   assign bus.credit_ovf = credit_ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         credit_q       <= '0;
         timer_q        <= '0;
         pulse_cnt_q    <= '0;
         q_serialized_q <= 1'b0;
         pulses_ended_q <= 1'b1;
         start_q        <= 1'b0;
`ifdef QPT_CREDIT_OVF_EN
         credit_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         credit_q       <= credit_d;
         timer_q        <= timer_d;
         pulse_cnt_q    <= pulse_cnt_d;
         q_serialized_q <= q_serialized_d;
         pulses_ended_q <= pulses_ended_d;
         start_q        <= start_d;
`ifdef QPT_CREDIT_OVF_EN
         credit_ovf_q   <= credit_ovf_d;
`endif
      end
   end

   assign bus.q_serialized = q_serialized_q;
   assign bus.pulses_ended = pulses_ended_q;
   assign bus.pulse_cnt    = pulse_cnt_q;
endmodule

// File: tb/tb_q_pulse_tx.sv
// Directed bench for q_pulse_tx: a vector table for reset and steady-rate emission, plus
// hand-written sequences for zero reference, max rate, drain on stop and reset mid-pulse.
module tb_q_pulse_tx;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   q_pulse_tx_if bus ();

   q_pulse_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        rst;
      logic        en;
      logic        st;
      logic [9:0]  iref;
      logic        q;
      logic        ended;
      logic [11:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [9:0] ir,
                               input logic q, input logic ended, input logic [11:0] c);
      vec_t v;
      v.rst = r; v.en = e; v.st = s; v.iref = ir;
      v.q = q; v.ended = ended; v.cnt = c;
      return v;
   endfunction

   // One transaction: inputs change on the falling edge, outputs are sampled just after the rising edge.
   task automatic drive(input logic r, input logic e, input logic s, input logic [9:0] ir);
      @(negedge clk);
      rst        = r;
      bus.enable = e;
      bus.start  = s;
      bus.i_ref  = ir;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic q, input logic ended,
                        input logic [11:0] cnt);
      n_cmp++;
      if (bus.q_serialized !== q || bus.pulses_ended !== ended || bus.pulse_cnt !== cnt) begin
         n_fail++;
         $display("FAIL %s[%0d]: got q=%b ended=%b cnt=%0d, expected q=%b ended=%b cnt=%0d",
                  name, idx, bus.q_serialized, bus.pulses_ended, bus.pulse_cnt, q, ended, cnt);
      end else begin
         $display("  %s[%0d]: q=%b ended=%b cnt=%0d ok", name, idx, bus.q_serialized,
                  bus.pulses_ended, bus.pulse_cnt);
      end
   endtask

`ifdef QPT_CREDIT_OVF_EN
   task automatic check_ovf(input string name, input logic exp);
      n_cmp++;
      if (bus.credit_ovf !== exp) begin
         n_fail++;
         $display("FAIL %s: got credit_ovf=%b, expected %b", name, bus.credit_ovf, exp);
      end else begin
         $display("  %s: credit_ovf=%b ok", name, bus.credit_ovf);
      end
   endtask
`endif

   initial begin
      int launches[$];
      logic        eq;
      logic [11:0] ec;

      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.start  = 1'b0;
      bus.i_ref  = '0;

      // Reset, idle, enable-only, then i_ref=128: launches at run edges 8k+1, high for 3 edges.
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 12'd0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 12'd0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 10'd128, 1'b0, 1'b1, 12'd0));
      for (int r = 1; r <= 84; r++)
         vecs.push_back(mk(1'b0, 1'b1, 1'b1, 10'd128,
                           (r >= 9) && (((r - 1) % 8) < 3), 1'b0, 12'((r - 1) / 8)));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].iref);
         check("table", i, vecs[i].q, vecs[i].ended, vecs[i].cnt);
      end
`ifdef QPT_CREDIT_OVF_EN
      check_ovf("steady_ovf", 1'b0);
`endif

      // Zero reference: no carries, nothing pending.
      drive(1'b1, 1'b0, 1'b0, 10'd0);
      check("zero_rst", 0, 1'b0, 1'b1, 12'd0);
      for (int r = 1; r <= 50; r++) begin
         drive(1'b0, 1'b1, 1'b1, 10'd0);
         check("zero", r, 1'b0, 1'b1, 12'd0);
      end

      // i_ref=256: carry every 4 edges, launches every 5 edges from edge 5.
      drive(1'b1, 1'b0, 1'b0, 10'd0);
      for (int r = 1; r <= 400; r++) begin
         drive(1'b0, 1'b1, 1'b1, 10'd256);
         if (r <= 60 || r == 400)
            check("maxrate", r, (r >= 5) && ((r % 5) < 3), 1'b0, 12'(r / 5));
`ifdef QPT_CREDIT_OVF_EN
         if (r == 60) check_ovf("maxrate_ovf_early", 1'b0);
`endif
      end
`ifdef QPT_CREDIT_OVF_EN
      check_ovf("maxrate_ovf_sat", 1'b1);
`endif

      // Drain: 19 run edges at 1023 (carries on edges 2..19), then stop during the pulse launched at 18.
      for (int j = 0; j < 4; j++) launches.push_back(3 + 5 * j);
      for (int j = 0; j < 14; j++) launches.push_back(23 + 5 * j);
      drive(1'b1, 1'b0, 1'b0, 10'd0);
      for (int r = 1; r <= 96; r++) begin
         drive(1'b0, 1'b1, (r <= 19), 10'd1023);
         eq = 1'b0;
         ec = 12'd0;
         foreach (launches[k]) begin
            if (launches[k] <= r) ec = ec + 12'd1;
            if (launches[k] <= r && r <= launches[k] + 2) eq = 1'b1;
         end
         check("drain", r, eq, (r >= 92), ec);
      end
`ifdef QPT_CREDIT_OVF_EN
      check_ovf("drain_ovf", 1'b0);
`endif

      // Reset on the second high cycle, then restart from a clean count.
      drive(1'b1, 1'b0, 1'b0, 10'd0);
      for (int r = 1; r <= 9; r++) drive(1'b0, 1'b1, 1'b1, 10'd128);
      check("rstmid_pre", 9, 1'b1, 1'b0, 12'd1);
      drive(1'b1, 1'b1, 1'b1, 10'd128);
      check("rstmid_edge", 10, 1'b0, 1'b1, 12'd0);
      drive(1'b0, 1'b1, 1'b0, 10'd128);
      check("rstmid_stop", 0, 1'b0, 1'b1, 12'd0);
      for (int r = 1; r <= 9; r++) begin
         drive(1'b0, 1'b1, 1'b1, 10'd128);
         check("rstmid_restart", r, (r == 9), 1'b0, (r == 9) ? 12'd1 : 12'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/q_pulse_tx.md
Name: q_pulse_tx

Overview:
- Synthesizable charge-pulse transmitter: the sending end of the q_serialized pulse interface that the Q-measurement path of top consumes.
- Converts the controller's i_ref_out current reference into a stream of fixed-width pulses.
- Pulse rate is proportional to i_ref via a phase accumulator; each pulse represents Q_PER_PULSE charge quanta.
- Replaces the behavioural resonant_sys emulation for gate-level and FPGA closed-loop runs.

Parameters:
- BUS_WIDTH, 10: width of i_ref.
- ACC_WIDTH, 10: phase accumulator width; one pulse per 2^ACC_WIDTH accumulated i_ref units.
- PULSE_DURATION, 3: q_serialized high time per pulse, in clk cycles; must be >= 1.
- GAP_DURATION, 1: minimum low time between pulses, in clk cycles; must be >= 1.
- CREDIT_WIDTH, 4: width of the pending-pulse credit counter.
- CNT_WIDTH, 12: width of the emitted-pulse counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global enable.
- start  in  1  run request (level); run = enable & start.
- i_ref  in  BUS_WIDTH  current reference, sampled every cycle while run.
- q_serialized  out  1  registered pulse output.
- pulses_ended  out  1  registered; high when nothing pending or in flight and generation stopped.
- pulse_cnt  out  CNT_WIDTH  pulses emitted since the last start rising edge; saturates at all-ones.

Behaviour:
- Reset: acc=0, credit=0, emitter state IDLE, q_serialized=0, pulses_ended=1, pulse_cnt=0, timer=0.
- Accumulator, each edge while run:
  - {carry, acc} <= acc + i_ref, with i_ref zero-extended to ACC_WIDTH+1.
  - When run=0, acc <= 0 (no residue carried into the next run).
- Credit counter:
  - carry=1 increments credit.
  - Emitter pulse launch decrements credit.
  - Both in the same cycle: credit unchanged.
  - Increment while credit is all-ones: credit saturates and the pulse is dropped.
- Start edge: start rising with enable=1 (start was 0 on the previous edge) clears pulse_cnt and acc on that edge.
- Emitter FSM:
  - IDLE: if credit>0, go to HIGH; q_serialized<=1; timer<=PULSE_DURATION-1; credit decrements; pulse_cnt increments (saturating).
  - HIGH: when timer==0, go to LOW; q_serialized<=0; timer<=GAP_DURATION-1. Otherwise timer decrements.
  - LOW: when timer==0, go to IDLE. Otherwise timer decrements.
  - LOW exits to IDLE and IDLE launches on the following edge, so the minimum pulse period is PULSE_DURATION+GAP_DURATION+1 cycles. Credit absorbs rate bursts above this limit.
- Latency: carry produced on edge k -> credit visible after edge k -> q_serialized rises on edge k+1.
- Run drop mid-pulse (start or enable falls):
  - Accumulation stops.
  - The current pulse completes its full width.
  - Remaining credit is still drained. Pulses are never truncated or discarded, except on rst.
- pulses_ended <= (credit==0) & (state==IDLE) & (!run | i_ref==0). The credit and state terms use the next-state values.
- i_ref=0 while run: no carries; pulses_ended rises once in-flight work drains.
- i_ref maximum (1023) with ACC_WIDTH=10: carry on nearly every edge, so credit saturates; the emitter runs at maximum rate.
- rst mid-pulse: q_serialized drops on that edge; all state returns to reset values.

Optional Feature:
- Macro QPT_CREDIT_OVF_EN.
- Defined: adds output port credit_ovf (1 bit). It is a sticky register set on any dropped pulse (increment at saturation without a launch), cleared by rst or by a start rising edge.
- Undefined: port absent; saturation drops pulses silently.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> q_serialized=0, pulses_ended=1, pulse_cnt=0 throughout.
- Steady rate: enable=1, start=1, i_ref=128 (ACC_WIDTH=10, PULSE_DURATION=3, GAP_DURATION=1).
  - Required: first carry at the 8th run edge; q_serialized high for 3 cycles starting one edge later.
  - Subsequent pulse period 8 cycles; pulse_cnt=10 after 10 pulses.
- Max-rate emission: i_ref=256.
  - Required: carry every 4 edges, pulse period 5 cycles; credit grows by 1 every 20 cycles.
  - With QPT_CREDIT_OVF_EN, credit_ovf sets once credit saturates at 15.
- Drain on stop:
  - i_ref=1023 for 20 cycles, then start=0 in the middle of a pulse.
  - Required: that pulse finishes at full width; all pending credits are emitted at 5-cycle spacing.
  - Required: pulses_ended rises the cycle the emitter returns to IDLE with credit=0.
- Zero reference: run with i_ref=0 for 50 cycles -> no pulses, pulses_ended=1, pulse_cnt=0.
- Reset mid-pulse: assert rst on the 2nd high cycle -> q_serialized=0 and pulses_ended=1 on that edge; restarting start gives pulse_cnt counting from 0.
